// File: rtl/eth_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : eth_pkg
//  Description : Shared constants and enumerations for the Ethernet TX path
//  Revision    : 1.0  initial release
// ============================================================================
package eth_pkg;

    localparam logic [15:0] ETH_TYPE_ARP    = 16'h0806;
    localparam logic [15:0] ETH_TYPE_IPV4   = 16'h0800;
    localparam logic [15:0] ARP_OPER_REQ    = 16'd1;
    localparam logic [15:0] ARP_OPER_REP    = 16'd2;
    localparam logic [7:0]  IP_PROTO_UDP    = 8'd17;
    localparam int          ARP_FRAME_WORDS = 16;
    // Ethernet (4) + IPv4 (5) + UDP (2) words ahead of the payload
    localparam int          UDP_HDR_WORDS   = 11;

    typedef enum logic [1:0] {
        KIND_NONE    = 2'd0,
        KIND_ARP_REQ = 2'd1,
        KIND_ARP_REP = 2'd2,
        KIND_UDP     = 2'd3
    } frame_kind_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/eth_send_ip_hdr_csum.sv
`default_nettype none
// ============================================================================
//  Module      : ip_hdr_csum
//  Description : Combinational IPv4 header checksum (one's complement of the
//                one's-complement sum of the nine non-checksum halfwords)
//  Revision    : 1.0  initial release
// ============================================================================
module ip_hdr_csum
    import eth_pkg::*;
(
    input  logic [15:0] i_total_len,
    input  logic [15:0] i_ident,
    input  logic [7:0]  i_ttl,
    input  logic [31:0] i_src_ip,
    input  logic [31:0] i_dst_ip,
    output logic [15:0] o_csum
);

    // Nine halfwords fit comfortably in 20 bits before folding
    logic [19:0] w_sum;
    logic [16:0] w_fold1;
    logic [15:0] w_fold2;

    // Raw sum of version/IHL/TOS, length, ident, flags, TTL/proto and addresses
    always_comb begin
        w_sum = 20'h04500
              + 20'(i_total_len)
              + 20'(i_ident)
              + 20'h04000
              + 20'({i_ttl, IP_PROTO_UDP})
              + 20'(i_src_ip[31:16]) + 20'(i_src_ip[15:0])
              + 20'(i_dst_ip[31:16]) + 20'(i_dst_ip[15:0]);
    end

    // The first fold is at most 0x1000E, so the second fold cannot carry again
    assign w_fold1 = 17'(w_sum[15:0]) + 17'(w_sum[19:16]);
    assign w_fold2 = w_fold1[15:0] + 16'(w_fold1[16]);
    assign o_csum  = ~w_fold2;

endmodule
`default_nettype wire

// File: rtl/eth_send.sv
`default_nettype none
// ============================================================================
//  Module      : eth_send
//  Description : Builds ARP request/reply and IPv4/UDP frames as a 32-bit
//                sop/eop/vld/rdy word stream for the MAC TX path
//  Revision    : 1.0  initial release
// ============================================================================
module eth_send
    import eth_pkg::*;
#(
    parameter int          UDP_PAYLOAD_WORDS = 8,
    parameter logic [15:0] UDP_SRC_PORT      = 16'd1456,
    parameter logic [7:0]  IP_TTL            = 8'h40
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [47:0] i_self_mac,
    input  logic [31:0] i_self_ip,
    input  logic        i_arp_req,
    input  logic        i_arp_reply,
    input  logic [47:0] i_arp_target_mac,
    input  logic [31:0] i_arp_target_ip,
    input  logic        i_udp_send,
    input  logic [47:0] i_udp_dst_mac,
    input  logic [31:0] i_udp_dst_ip,
    input  logic [15:0] i_udp_dst_port,
    input  logic [31:0] i_pl_data,
    output logic        o_pl_rd,
    output logic [31:0] o_data,
    output logic        o_vld,
    input  logic        i_rdy,
    output logic        o_sop,
    output logic        o_eop,
    output logic        o_busy
);

    localparam logic [15:0] c_ip_len   = 16'(28 + 4 * UDP_PAYLOAD_WORDS);
    localparam logic [15:0] c_udp_len  = 16'(8 + 4 * UDP_PAYLOAD_WORDS);
    localparam logic [8:0]  c_last_arp = 9'(ARP_FRAME_WORDS - 1);
    localparam logic [8:0]  c_last_udp = 9'(UDP_HDR_WORDS + UDP_PAYLOAD_WORDS - 1);
    localparam logic [8:0]  c_pl_first = 9'(UDP_HDR_WORDS);

    state_t      r_state, w_next;
    frame_kind_t w_sel_kind, r_kind;

    logic        r_pend_rep, r_pend_req, r_pend_udp;
    logic [47:0] r_rep_mac, r_udp_mac;
    logic [31:0] r_rep_ip, r_req_ip, r_udp_ip;
    logic [15:0] r_udp_port;

    logic [47:0] r_dst_mac, r_tha, r_self_mac;
    logic [31:0] r_tip, r_self_ip;
    logic [15:0] r_dport, r_csum, r_ident;
    logic [8:0]  r_cnt;

    logic        w_load, w_last, w_xfer, w_eop_xfer;
    logic [15:0] w_csum, w_type, w_oper;

    assign w_load     = (r_state == ST_LOAD);
    assign w_last     = (r_cnt == ((r_kind == KIND_UDP) ? c_last_udp : c_last_arp));
    assign w_xfer     = o_vld && i_rdy;
    assign w_eop_xfer = w_xfer && w_last;
    assign o_busy     = (r_state != ST_IDLE) || r_pend_rep || r_pend_req || r_pend_udp;
    assign w_type     = (r_kind == KIND_UDP) ? ETH_TYPE_IPV4 : ETH_TYPE_ARP;
    assign w_oper     = (r_kind == KIND_ARP_REP) ? ARP_OPER_REP : ARP_OPER_REQ;

    // Checksum is evaluated against the pending UDP operands and captured in LOAD
    ip_hdr_csum u_csum (
        .i_total_len (c_ip_len),
        .i_ident     (r_ident),
        .i_ttl       (IP_TTL),
        .i_src_ip    (i_self_ip),
        .i_dst_ip    (r_udp_ip),
        .o_csum      (w_csum)
    );

    // Next frame to serve: ARP reply beats ARP request beats UDP
    always_comb begin
        w_sel_kind = KIND_NONE;
        if (r_pend_rep)      w_sel_kind = KIND_ARP_REP;
        else if (r_pend_req) w_sel_kind = KIND_ARP_REQ;
        else if (r_pend_udp) w_sel_kind = KIND_UDP;
    end

    // Single-entry request slots; a new pulse wins over the clear on the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend_rep <= 1'b0;
            r_pend_req <= 1'b0;
            r_pend_udp <= 1'b0;
            r_rep_mac  <= '0;
            r_rep_ip   <= '0;
            r_req_ip   <= '0;
            r_udp_mac  <= '0;
            r_udp_ip   <= '0;
            r_udp_port <= '0;
        end else begin
            if (i_arp_reply) begin
                r_pend_rep <= 1'b1;
                r_rep_mac  <= i_arp_target_mac;
                r_rep_ip   <= i_arp_target_ip;
            end else if (w_load && w_sel_kind == KIND_ARP_REP) begin
                r_pend_rep <= 1'b0;
            end
            if (i_arp_req) begin
                r_pend_req <= 1'b1;
                r_req_ip   <= i_arp_target_ip;
            end else if (w_load && w_sel_kind == KIND_ARP_REQ) begin
                r_pend_req <= 1'b0;
            end
            if (i_udp_send) begin
                r_pend_udp <= 1'b1;
                r_udp_mac  <= i_udp_dst_mac;
                r_udp_ip   <= i_udp_dst_ip;
                r_udp_port <= i_udp_dst_port;
            end else if (w_load && w_sel_kind == KIND_UDP) begin
                r_pend_udp <= 1'b0;
            end
        end
    end

    // Freeze the frame's operands in LOAD so the words stay stable during SEND
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_kind     <= KIND_NONE;
            r_dst_mac  <= '0;
            r_tha      <= '0;
            r_tip      <= '0;
            r_dport    <= '0;
            r_csum     <= '0;
            r_self_mac <= '0;
            r_self_ip  <= '0;
        end else if (w_load) begin
            r_kind     <= w_sel_kind;
            r_self_mac <= i_self_mac;
            r_self_ip  <= i_self_ip;
            r_csum     <= w_csum;
            r_dport    <= r_udp_port;
            case (w_sel_kind)
                KIND_ARP_REP: begin
                    r_dst_mac <= r_rep_mac;
                    r_tha     <= r_rep_mac;
                    r_tip     <= r_rep_ip;
                end
                KIND_ARP_REQ: begin
                    r_dst_mac <= 48'hFFFF_FFFF_FFFF;
                    r_tha     <= '0;
                    r_tip     <= r_req_ip;
                end
                default: begin
                    r_dst_mac <= r_udp_mac;
                    r_tha     <= '0;
                    r_tip     <= r_udp_ip;
                end
            endcase
        end
    end

    // Word counter restarts in LOAD and advances on each accepted word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_load) begin
            r_cnt <= '0;
        end else if (w_xfer) begin
            r_cnt <= w_last ? 9'd0 : r_cnt + 9'd1;
        end
    end

    // IP identification advances once per completed UDP frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ident <= '0;
        end else if (w_eop_xfer && r_kind == KIND_UDP) begin
            r_ident <= r_ident + 16'd1;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    // Next state and stream handshake outputs
    always_comb begin
        w_next  = r_state;
        o_vld   = 1'b0;
        o_sop   = 1'b0;
        o_eop   = 1'b0;
        o_pl_rd = 1'b0;
        case (r_state)
            ST_IDLE: if (w_sel_kind != KIND_NONE) w_next = ST_LOAD;
            ST_LOAD: w_next = ST_SEND;
            ST_SEND: begin
                o_vld   = 1'b1;
                o_sop   = (r_cnt == 9'd0);
                o_eop   = w_last;
                o_pl_rd = (r_kind == KIND_UDP) && (r_cnt >= c_pl_first) && i_rdy;
                if (i_rdy && w_last) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Word multiplexer; payload words pass straight through from the show-ahead source
    always_comb begin
        o_data = 32'h0;
        if (r_state == ST_SEND) begin
            if (r_cnt < 9'd4) begin
                case (r_cnt[1:0])
                    2'd0:    o_data = {16'h0000, r_dst_mac[47:32]};
                    2'd1:    o_data = r_dst_mac[31:0];
                    2'd2:    o_data = r_self_mac[47:16];
                    default: o_data = {r_self_mac[15:0], w_type};
                endcase
            end else if (r_kind == KIND_UDP) begin
                case (r_cnt)
                    9'd4:    o_data = {8'h45, 8'h00, c_ip_len};
                    9'd5:    o_data = {r_ident, 16'h4000};
                    9'd6:    o_data = {IP_TTL, IP_PROTO_UDP, r_csum};
                    9'd7:    o_data = r_self_ip;
                    9'd8:    o_data = r_tip;
                    9'd9:    o_data = {UDP_SRC_PORT, r_dport};
                    9'd10:   o_data = {c_udp_len, 16'h0000};
                    default: o_data = i_pl_data;
                endcase
            end else begin
                case (r_cnt)
                    9'd4:    o_data = 32'h0001_0800;
                    9'd5:    o_data = {8'h06, 8'h04, w_oper};
                    9'd6:    o_data = r_self_mac[47:16];
                    9'd7:    o_data = {r_self_mac[15:0], r_self_ip[31:16]};
                    9'd8:    o_data = {r_self_ip[15:0], r_tha[47:32]};
                    9'd9:    o_data = r_tha[31:0];
                    9'd10:   o_data = r_tip;
                    default: o_data = 32'h0;
                endcase
            end
        end
    end

endmodule
`default_nettype wire
